// File: rtl/sdrc_wb_bist_pkg.sv
// rtl/sdrc_wb_bist_pkg.sv - shared state encoding, CTI codes and LFSR step for the WB BIST master
package sdrc_wb_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_INIT = 3'd1,
      ST_WR_BURST  = 3'd2,
      ST_WR_GAP    = 3'd3,
      ST_RD_BURST  = 3'd4,
      ST_RD_GAP    = 3'd5,
      ST_FIN       = 3'd6
   } bist_state_t;

   localparam logic [2:0]  CTI_INCR  = 3'b010;
   localparam logic [2:0]  CTI_EOB   = 3'b111;
   localparam logic [31:0] LFSR_TAPS = 32'h80200003;

   // Right-shifting Galois step for x^32+x^22+x^2+x+1
   function automatic logic [31:0] lfsr_next(input logic [31:0] v);
      return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
   endfunction

endpackage

// File: rtl/sdrc_bist_lfsr.sv
// rtl/sdrc_bist_lfsr.sv - 32-bit pattern LFSR with synchronous load and step
module sdrc_bist_lfsr
   import sdrc_wb_bist_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_load,
   input  logic [31:0] i_seed,
   input  logic        i_step,
   output logic [31:0] o_value
);

   logic [31:0] r_value;

   // Load wins over step so a reload at the phase change starts cleanly
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)    r_value <= '0;
      else if (i_load) r_value <= i_seed;
      else if (i_step) r_value <= lfsr_next(r_value);
   end

   assign o_value = r_value;

endmodule

// File: rtl/sdrc_wb_bist.sv
// rtl/sdrc_wb_bist.sv - WB burst master that writes an LFSR pattern over a window and reads it back
module sdrc_wb_bist
   import sdrc_wb_bist_pkg::*;
#(
   parameter int APP_AW = 26,
   parameter int dw     = 32,
   parameter int BL_MAX = 8,
   parameter int TMO_W  = 10
) (
   input  logic              sdram_clk,
   input  logic              sdram_resetn,
   input  logic              sdr_init_done,
   input  logic              bist_start,
   input  logic [APP_AW-1:0] cfg_base_addr,
   input  logic [15:0]       cfg_len,
   input  logic [3:0]        cfg_burst,
   input  logic [31:0]       cfg_seed,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [APP_AW-1:0] wb_addr_o,
   output logic [dw-1:0]     wb_dat_o,
   output logic [dw/8-1:0]   wb_sel_o,
   output logic [2:0]        wb_cti_o,
   input  logic              wb_ack_i,
   input  logic [dw-1:0]     wb_dat_i,
   output logic              bist_busy,
   output logic              bist_done,
   output logic              bist_pass,
   output logic              bist_tmo,
   output logic [15:0]       bist_err_cnt,
   output logic [APP_AW-1:0] bist_err_addr
);

   localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
   localparam logic [3:0]       BURST_MAX = 4'(BL_MAX);

   bist_state_t       r_state, w_state_nxt;
   logic [15:0]       r_len, r_rem, r_err_cnt;
   logic [APP_AW-1:0] r_base, r_addr, r_err_addr;
   logic [31:0]       r_seed;
   logic [3:0]        r_burst, r_beats;
   logic [TMO_W-1:0]  r_wdog;
   logic [2:0]        r_cti;
   logic              r_cyc, r_we, r_busy, r_done, r_pass, r_tmo;

   logic              w_start, w_ack, w_wdog_fire, w_phase_flip, w_in_burst_nxt, w_enter_burst;
   logic [15:0]       w_rem_src;
   logic [3:0]        w_beats_new, w_burst_eff;
   logic [31:0]       w_seed_eff, w_lfsr_seed, w_lfsr_val;

   assign w_start        = (r_state == ST_IDLE) && bist_start;
   assign w_ack          = wb_ack_i && r_cyc;
   // Fires on the cycle that would make the stall count all-ones
   assign w_wdog_fire    = r_cyc && !wb_ack_i && (r_wdog == WDOG_LAST);
   assign w_phase_flip   = (r_state == ST_WR_GAP) && (r_rem == 16'd0);
   assign w_in_burst_nxt = (w_state_nxt == ST_WR_BURST) || (w_state_nxt == ST_RD_BURST);
   assign w_enter_burst  = w_in_burst_nxt && !r_cyc;
   assign w_rem_src      = w_phase_flip ? r_len : r_rem;
   assign w_beats_new    = (w_rem_src < {12'd0, r_burst}) ? w_rem_src[3:0] : r_burst;
   assign w_burst_eff    = (cfg_burst == 4'd0) ? 4'd1 :
                           (cfg_burst > BURST_MAX) ? BURST_MAX : cfg_burst;
   assign w_seed_eff     = (cfg_seed == 32'd0) ? 32'd1 : cfg_seed;
   assign w_lfsr_seed    = w_start ? w_seed_eff : r_seed;

   sdrc_bist_lfsr u_lfsr (
      .i_clk   (sdram_clk),
      .i_rst_n (sdram_resetn),
      .i_load  (w_start || w_phase_flip),
      .i_seed  (w_lfsr_seed),
      .i_step  (w_ack),
      .o_value (w_lfsr_val)
   );

   // State register
   always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) r_state <= ST_IDLE;
      else               r_state <= w_state_nxt;
   end

   // Next-state: bursts end on the ack of their last beat, gaps last one cycle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:      if (bist_start) w_state_nxt = ST_WAIT_INIT;
         ST_WAIT_INIT: if (sdr_init_done) w_state_nxt = (r_len == 16'd0) ? ST_FIN : ST_WR_BURST;
         ST_WR_BURST:  if (w_wdog_fire) w_state_nxt = ST_FIN;
                       else if (w_ack && r_beats == 4'd1) w_state_nxt = ST_WR_GAP;
         ST_WR_GAP:    w_state_nxt = (r_rem == 16'd0) ? ST_RD_BURST : ST_WR_BURST;
         ST_RD_BURST:  if (w_wdog_fire) w_state_nxt = ST_FIN;
                       else if (w_ack && r_beats == 4'd1) w_state_nxt = ST_RD_GAP;
         ST_RD_GAP:    w_state_nxt = (r_rem == 16'd0) ? ST_FIN : ST_RD_BURST;
         ST_FIN:       w_state_nxt = ST_IDLE;
         default:      w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath and registered outputs, all derived from the next state
   always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         r_len <= '0; r_rem <= '0; r_err_cnt <= '0; r_base <= '0; r_addr <= '0;
         r_err_addr <= '0; r_seed <= '0; r_burst <= '0; r_beats <= '0; r_wdog <= '0;
         r_cti <= '0; r_cyc <= 1'b0; r_we <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0;
         r_pass <= 1'b0; r_tmo <= 1'b0;
      end else begin
         r_cyc  <= w_in_burst_nxt;
         r_we   <= (w_state_nxt == ST_WR_BURST);
         r_busy <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_FIN);
         if (w_start) begin
            r_len      <= cfg_len;
            r_rem      <= cfg_len;
            r_base     <= {cfg_base_addr[APP_AW-1:2], 2'b00};
            r_addr     <= {cfg_base_addr[APP_AW-1:2], 2'b00};
            r_seed     <= w_seed_eff;
            r_burst    <= w_burst_eff;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_tmo      <= 1'b0;
            r_err_cnt  <= '0;
            r_err_addr <= '0;
         end
         if (w_phase_flip) begin
            r_addr <= r_base;
            r_rem  <= r_len;
         end
         if (w_enter_burst) begin
            r_beats <= w_beats_new;
            r_cti   <= (w_beats_new == 4'd1) ? CTI_EOB : CTI_INCR;
         end else if (w_ack) begin
            r_addr  <= r_addr + APP_AW'(4);
            r_rem   <= r_rem - 16'd1;
            r_beats <= r_beats - 4'd1;
            r_cti   <= (r_beats == 4'd2) ? CTI_EOB : CTI_INCR;
         end
         if (!w_in_burst_nxt) r_cti <= '0;
         if (!r_cyc || w_ack) r_wdog <= '0;
         else                 r_wdog <= r_wdog + 1'b1;
         if (w_wdog_fire) r_tmo <= 1'b1;
         if (w_ack && !r_we && (wb_dat_i != w_lfsr_val)) begin
            if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            if (r_err_cnt == 16'd0)    r_err_addr <= r_addr;
         end
         if (w_state_nxt == ST_FIN) begin
            r_done <= 1'b1;
            r_pass <= (r_err_cnt == 16'd0) && !w_wdog_fire;
         end
      end
   end

   assign wb_cyc_o      = r_cyc;
   assign wb_stb_o      = r_cyc;
   assign wb_we_o       = r_we;
   assign wb_addr_o     = r_addr;
   assign wb_dat_o      = w_lfsr_val;
   assign wb_sel_o      = '1;
   assign wb_cti_o      = r_cti;
   assign bist_busy     = r_busy;
   assign bist_done     = r_done;
   assign bist_pass     = r_pass;
   assign bist_tmo      = r_tmo;
   assign bist_err_cnt  = r_err_cnt;
   assign bist_err_addr = r_err_addr;

endmodule
